// File: rtl/prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// prog_loader_pkg
// Shared definitions for the multi-channel UART program loader: the frame
// parser state encoding, the error codes reported on err_code_o, the default
// frame start marker and the checksum accumulation helper.
// No ports (package).
// -----------------------------------------------------------------------------
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHAN   = 3'd1,
        LEN_LO = 3'd2,
        LEN_HI = 3'd3,
        DATA   = 3'd4,
        CSUM   = 3'd5
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CSUM    = 2'd1;
    localparam logic [1:0] ERR_HDR     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    // Running frame checksum: plain XOR of every byte from CHAN to the last
    // data byte.
    function automatic logic [7:0] csum_update(input logic [7:0] acc,
                                               input logic [7:0] data_byte);
        return acc ^ data_byte;
    endfunction

endpackage

// File: rtl/prog_word_assembler.sv
// -----------------------------------------------------------------------------
// prog_word_assembler
// Collects DATA_W/8 bytes, least significant byte first, into one word.
// word_valid_o/word_o are combinational so the parent can register the write
// strobe on the same edge that accepts the last byte of the word.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   clear_i           restart at byte 0 (held while no word is being received)
//   byte_en_i         byte_i is valid this cycle
//   byte_i[7:0]       incoming byte
//   word_valid_o      byte_i completes a word this cycle
//   word_o[DATA_W-1:0] the completed word (valid with word_valid_o)
// -----------------------------------------------------------------------------
module prog_word_assembler
    import prog_loader_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              byte_en_i,
    input  logic [7:0]        byte_i,
    output logic              word_valid_o,
    output logic [DATA_W-1:0] word_o
);

    localparam int BPW   = DATA_W / 8;
    localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W-1:0] shift_r;
    logic [DATA_W-1:0] merged_s;
    logic              last_s;

    // Merge the incoming byte into its lane so the full word is available
    // in the same cycle as the final byte.
    always_comb begin
        merged_s = shift_r;
        merged_s[int'(cnt_r) * 8 +: 8] = byte_i;
        last_s       = (cnt_r == CNT_W'(BPW - 1));
        word_valid_o = byte_en_i & last_s;
        word_o       = merged_s;
    end

    // Byte lane counter and partial-word storage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r   <= {CNT_W{1'b0}};
            shift_r <= {DATA_W{1'b0}};
        end else if (clear_i) begin
            cnt_r   <= {CNT_W{1'b0}};
            shift_r <= {DATA_W{1'b0}};
        end else if (byte_en_i) begin
            shift_r <= merged_s;
            cnt_r   <= last_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
        end else begin
            cnt_r   <= cnt_r;
            shift_r <= shift_r;
        end
    end

endmodule

// File: rtl/prog_loader_mc.sv
// -----------------------------------------------------------------------------
// prog_loader_mc
// Multi-channel UART program loader. Parses frames
//   SYNC, CHAN, LEN_LO, LEN_HI, LEN*BPW data bytes, CSUM
// from the UART receive byte stream and writes the assembled words to the
// memory port selected by CHAN. Holds the core in reset while programming.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   prog_i                  programming mode enable (bytes ignored while low)
//   rx_dv_i, rx_byte_i[7:0] received byte strobe and data
//   we_o[NUM_CH-1:0]        one-hot write strobe, one cycle per word
//   addr_o[ADDR_W-1:0]      word address of the write
//   wdata_o[DATA_W-1:0]     write data
//   core_hold_o             hold core/system in reset
//   done_o                  pulse: frame accepted, checksum OK
//   err_o                   pulse: frame error of any kind
//   err_code_o[1:0]         last error code, sticky until the next SYNC
// -----------------------------------------------------------------------------
module prog_loader_mc
    import prog_loader_pkg::*;
#(
    parameter int         DATA_W      = 32,
    parameter int         ADDR_W      = 12,
    parameter int         NUM_CH      = 2,
    parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              prog_i,
    input  logic              rx_dv_i,
    input  logic [7:0]        rx_byte_i,
    output logic [NUM_CH-1:0] we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              core_hold_o,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        err_code_o
);

    localparam int          TMO_W     = $clog2(TIMEOUT_CYC + 1);
    // Largest word count that still fits the channel address space.
    localparam logic [31:0] LEN_LIMIT = 32'd1 << ADDR_W;

    state_e              state_r;
    state_e              next_state_s;

    logic                byte_en_s;
    logic                abort_s;
    logic                tmo_hit_s;
    logic [TMO_W-1:0]    tmo_r;

    logic [7:0]          csum_r;
    logic [7:0]          ch_r;
    logic [7:0]          len_lo_r;
    logic [15:0]         len_s;
    logic                len_bad_s;
    logic                len_zero_s;
    logic                ch_bad_s;
    logic [15:0]         rem_r;
    logic [ADDR_W-1:0]   addr_r;

    logic                word_valid_s;
    logic [DATA_W-1:0]   word_s;
    logic                last_word_s;

    logic                wr_s;
    logic [NUM_CH-1:0]   we_s;
    logic                done_s;
    logic                err_s;
    logic                code_wr_s;
    logic [1:0]          code_nxt_s;

    // Header field decode shared by the next-state and output logic.
    always_comb begin
        byte_en_s   = prog_i & rx_dv_i;
        abort_s     = (state_r != IDLE) & ~prog_i;
        tmo_hit_s   = (state_r != IDLE) & ~byte_en_s & (tmo_r == TMO_W'(TIMEOUT_CYC - 1));
        len_s       = {rx_byte_i, len_lo_r};
        len_bad_s   = ({16'd0, len_s} > LEN_LIMIT);
        len_zero_s  = (len_s == 16'd0);
        ch_bad_s    = ({24'd0, rx_byte_i} >= 32'(NUM_CH));
        last_word_s = word_valid_s & (rem_r == 16'd1);
    end

    prog_word_assembler #(
        .DATA_W (DATA_W)
    ) u_asm (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (state_r != DATA),
        .byte_en_i    (byte_en_s & (state_r == DATA)),
        .byte_i       (rx_byte_i),
        .word_valid_o (word_valid_s),
        .word_o       (word_s)
    );

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next state: prog_i drop and timeout take priority over bytes.
    always_comb begin
        next_state_s = state_r;
        if (abort_s) begin
            next_state_s = IDLE;
        end else if (tmo_hit_s) begin
            next_state_s = IDLE;
        end else if (byte_en_s) begin
            case (state_r)
                IDLE:    next_state_s = (rx_byte_i == SYNC_BYTE) ? CHAN : IDLE;
                CHAN:    next_state_s = ch_bad_s ? IDLE : LEN_LO;
                LEN_LO:  next_state_s = LEN_HI;
                LEN_HI: begin
                    if (len_bad_s) begin
                        next_state_s = IDLE;
                    end else if (len_zero_s) begin
                        next_state_s = CSUM;
                    end else begin
                        next_state_s = DATA;
                    end
                end
                DATA:    next_state_s = last_word_s ? CSUM : DATA;
                CSUM:    next_state_s = IDLE;
                default: next_state_s = IDLE;
            endcase
        end else begin
            next_state_s = state_r;
        end
    end

    // FSM outputs: write, completion and error events for this cycle.
    always_comb begin
        wr_s       = 1'b0;
        done_s     = 1'b0;
        err_s      = 1'b0;
        code_wr_s  = 1'b0;
        code_nxt_s = ERR_NONE;
        if (abort_s) begin
            // Silent abort: no error is reported.
            wr_s = 1'b0;
        end else if (tmo_hit_s) begin
            err_s      = 1'b1;
            code_wr_s  = 1'b1;
            code_nxt_s = ERR_TIMEOUT;
        end else if (byte_en_s) begin
            case (state_r)
                IDLE: begin
                    code_wr_s = (rx_byte_i == SYNC_BYTE);
                end
                CHAN: begin
                    err_s      = ch_bad_s;
                    code_wr_s  = ch_bad_s;
                    code_nxt_s = ERR_HDR;
                end
                LEN_HI: begin
                    err_s      = len_bad_s;
                    code_wr_s  = len_bad_s;
                    code_nxt_s = ERR_HDR;
                end
                DATA: begin
                    wr_s = word_valid_s;
                end
                CSUM: begin
                    code_wr_s = 1'b1;
                    if (rx_byte_i == csum_r) begin
                        done_s     = 1'b1;
                        code_nxt_s = ERR_NONE;
                    end else begin
                        err_s      = 1'b1;
                        code_nxt_s = ERR_CSUM;
                    end
                end
                default: begin
                    wr_s = 1'b0;
                end
            endcase
        end else begin
            wr_s = 1'b0;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            we_s[i] = wr_s & (ch_r == 8'(i));
        end
    end

    // Frame datapath: checksum, channel, length, address and timeout counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            csum_r   <= 8'd0;
            ch_r     <= 8'd0;
            len_lo_r <= 8'd0;
            rem_r    <= 16'd0;
            addr_r   <= {ADDR_W{1'b0}};
            tmo_r    <= {TMO_W{1'b0}};
        end else begin
            if (state_r == IDLE || byte_en_s || tmo_hit_s) begin
                tmo_r <= {TMO_W{1'b0}};
            end else begin
                tmo_r <= tmo_r + TMO_W'(1);
            end
            if (byte_en_s && !abort_s) begin
                case (state_r)
                    IDLE: begin
                        csum_r <= 8'd0;
                    end
                    CHAN: begin
                        ch_r   <= rx_byte_i;
                        csum_r <= csum_update(csum_r, rx_byte_i);
                    end
                    LEN_LO: begin
                        len_lo_r <= rx_byte_i;
                        csum_r   <= csum_update(csum_r, rx_byte_i);
                    end
                    LEN_HI: begin
                        rem_r  <= len_s;
                        addr_r <= {ADDR_W{1'b0}};
                        csum_r <= csum_update(csum_r, rx_byte_i);
                    end
                    DATA: begin
                        csum_r <= csum_update(csum_r, rx_byte_i);
                        if (word_valid_s) begin
                            rem_r  <= rem_r - 16'd1;
                            addr_r <= addr_r + ADDR_W'(1);
                        end else begin
                            rem_r  <= rem_r;
                            addr_r <= addr_r;
                        end
                    end
                    default: begin
                        csum_r <= csum_r;
                    end
                endcase
            end else begin
                csum_r <= csum_r;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_o        <= {NUM_CH{1'b0}};
            addr_o      <= {ADDR_W{1'b0}};
            wdata_o     <= {DATA_W{1'b0}};
            core_hold_o <= 1'b1;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            err_code_o  <= ERR_NONE;
        end else begin
            we_o        <= we_s;
            core_hold_o <= prog_i | (state_r != IDLE);
            done_o      <= done_s;
            err_o       <= err_s;
            if (wr_s) begin
                addr_o  <= addr_r;
                wdata_o <= word_s;
            end else begin
                addr_o  <= addr_o;
                wdata_o <= wdata_o;
            end
            if (code_wr_s) begin
                err_code_o <= code_nxt_s;
            end else begin
                err_code_o <= err_code_o;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader_mc.sv
// -----------------------------------------------------------------------------
// tb_prog_loader_mc
// Directed bench for prog_loader_mc (DATA_W=32, ADDR_W=12, NUM_CH=2,
// TIMEOUT_CYC=50). Expected write/done/error events are queued as frames are
// driven and compared by an output monitor as they appear.
// -----------------------------------------------------------------------------
module tb_prog_loader_mc;

    typedef struct {
        logic [1:0]  we;
        logic [11:0] addr;
        logic [31:0] data;
        logic        done;
        logic        err;
        logic [1:0]  code;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prog = 1'b0;
    logic        rx_dv = 1'b0;
    logic [7:0]  rx_byte = 8'd0;
    logic [1:0]  we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        core_hold;
    logic        done;
    logic        err;
    logic [1:0]  err_code;

    int  checks = 0;
    int  errors = 0;
    ev_t sb[$];
    ev_t mon_e;

    always #5 clk = ~clk;

    prog_loader_mc #(
        .DATA_W      (32),
        .ADDR_W      (12),
        .NUM_CH      (2),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (50)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .prog_i      (prog),
        .rx_dv_i     (rx_dv),
        .rx_byte_i   (rx_byte),
        .we_o        (we),
        .addr_o      (addr),
        .wdata_o     (wdata),
        .core_hold_o (core_hold),
        .done_o      (done),
        .err_o       (err),
        .err_code_o  (err_code)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_wr(input logic [1:0] w, input logic [11:0] a, input logic [31:0] d);
        ev_t e;
        e.we = w; e.addr = a; e.data = d; e.done = 1'b0; e.err = 1'b0; e.code = 2'd0;
        sb.push_back(e);
    endtask

    task automatic push_st(input logic dn, input logic er, input logic [1:0] c);
        ev_t e;
        e.we = 2'b00; e.addr = 12'd0; e.data = 32'd0; e.done = dn; e.err = er; e.code = c;
        sb.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_dv   = 1'b1;
        rx_byte = b;
    endtask

    task automatic end_bytes();
        @(negedge clk);
        rx_dv = 1'b0;
    endtask

    task automatic settle(input int n, input string tag);
        repeat (n) @(negedge clk);
        #2;
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    // Drive a complete frame (up to two words) and queue the events it must cause.
    task automatic frame(input logic [7:0] ch, input int nw, input logic [31:0] w0,
                         input logic [31:0] w1, input bit corrupt);
        logic [31:0] w [2];
        logic [7:0]  cs;
        logic [15:0] len;
        w[0] = w0;
        w[1] = w1;
        len  = 16'(nw);
        if (ch >= 8'd2) begin
            push_st(1'b0, 1'b1, 2'd2);
            send_byte(8'hA5);
            send_byte(ch);
            end_bytes();
        end else begin
            cs = ch ^ len[7:0] ^ len[15:8];
            for (int i = 0; i < nw; i++) begin
                push_wr(2'b01 << ch, 12'(i), w[i]);
                for (int j = 0; j < 4; j++) cs = cs ^ w[i][8*j +: 8];
            end
            if (corrupt) push_st(1'b0, 1'b1, 2'd1);
            else         push_st(1'b1, 1'b0, 2'd0);
            send_byte(8'hA5);
            send_byte(ch);
            send_byte(len[7:0]);
            send_byte(len[15:8]);
            for (int i = 0; i < nw; i++)
                for (int j = 0; j < 4; j++) send_byte(w[i][8*j +: 8]);
            send_byte(corrupt ? (cs ^ 8'h40) : cs);
            end_bytes();
        end
    endtask

    // Output monitor: every write/done/error cycle must match the next queued event.
    always @(negedge clk) begin
        if (!rst && (we != 2'b00 || done || err)) begin
            if (sb.size() == 0) begin
                check("unexpected_event", {59'd0, we, done, err, 1'b0}, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("we", 64'(we), 64'(mon_e.we));
                check("done", 64'(done), 64'(mon_e.done));
                check("err", 64'(err), 64'(mon_e.err));
                if (mon_e.we != 2'b00) begin
                    check("addr", 64'(addr), 64'(mon_e.addr));
                    check("wdata", 64'(wdata), 64'(mon_e.data));
                end
                if (mon_e.done || mon_e.err) check("err_code", 64'(err_code), 64'(mon_e.code));
            end
        end
    end

    initial begin
        // Reset values.
        @(negedge clk);
        #1;
        check("rst_we", 64'(we), 64'd0);
        check("rst_addr", 64'(addr), 64'd0);
        check("rst_wdata", 64'(wdata), 64'd0);
        check("rst_hold", 64'(core_hold), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_code", 64'(err_code), 64'd0);

        // Release: hold drops after the first clock with prog low.
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("hold_at_release", 64'(core_hold), 64'd1);
        @(negedge clk);
        #1;
        check("hold_dropped", 64'(core_hold), 64'd0);

        // Bytes ignored while prog is low.
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        end_bytes();
        settle(5, "prog_low_ignored");
        check("hold_prog_low", 64'(core_hold), 64'd0);

        prog = 1'b1;
        @(negedge clk);
        #1;
        check("hold_prog_high", 64'(core_hold), 64'd1);

        // Two-word frames on both channels.
        frame(8'd0, 2, 32'h12345678, 32'hDEADBEEF, 1'b0);
        settle(6, "frame_ch0");
        frame(8'd1, 2, 32'h12345678, 32'hDEADBEEF, 1'b0);
        settle(6, "frame_ch1");

        // Bad channel: sticky code 2, cleared by the next SYNC.
        frame(8'd2, 2, 32'h12345678, 32'hDEADBEEF, 1'b0);
        settle(6, "frame_badch");
        check("code_sticky", 64'(err_code), 64'd2);
        push_st(1'b0, 1'b1, 2'd2);
        send_byte(8'hA5);
        @(posedge clk);
        #1;
        check("code_clr_sync", 64'(err_code), 64'd0);
        send_byte(8'h03);
        end_bytes();
        settle(6, "badch_03");

        // Checksum error: words still written.
        frame(8'd0, 2, 32'hA1B2C3D4, 32'h0BADF00D, 1'b1);
        settle(6, "frame_csum_err");

        // Zero length, then a length beyond the address space.
        frame(8'd1, 0, 32'd0, 32'd0, 1'b0);
        settle(6, "frame_len0");
        push_st(1'b0, 1'b1, 2'd2);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h10);
        end_bytes();
        settle(6, "frame_len_big");

        // Timeout after A5,00 then silence; error must not appear early.
        send_byte(8'hA5); send_byte(8'h00);
        end_bytes();
        repeat (44) @(negedge clk);
        push_st(1'b0, 1'b1, 2'd3);
        settle(20, "timeout");
        check("code_timeout", 64'(err_code), 64'd3);
        frame(8'd1, 2, 32'hCAFEF00D, 32'h00C0FFEE, 1'b0);
        settle(6, "after_timeout");

        // prog drop after the header: silent abort, no writes.
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02); send_byte(8'h00); send_byte(8'h78);
        end_bytes();
        prog = 1'b0;
        send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        end_bytes();
        #1;
        check("hold_after_abort", 64'(core_hold), 64'd0);
        prog = 1'b1;
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        end_bytes();
        settle(6, "prog_abort");

        // Asynchronous reset mid-DATA.
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h78); send_byte(8'h56);
        @(negedge clk);
        rx_dv = 1'b0;
        rst   = 1'b1;
        #1;
        check("arst_we", 64'(we), 64'd0);
        check("arst_addr", 64'(addr), 64'd0);
        check("arst_wdata", 64'(wdata), 64'd0);
        check("arst_hold", 64'(core_hold), 64'd1);
        check("arst_code", 64'(err_code), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'h34); send_byte(8'h12); send_byte(8'h00);
        end_bytes();
        settle(6, "after_arst");
        frame(8'd0, 1, 32'h5EED1234, 32'd0, 1'b0);
        settle(6, "recover");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_loader_mc.md
Name: prog_loader_mc

Overview:
- Parametrised successor to the single-memory UART program loader.
- Consumes a byte stream from the UART receive front end and assembles DATA_W-wide words. Steers them to one of NUM_CH memory write ports (ICCM, DCCM, ...) selected per frame.
- Adds framing, a length field, XOR checksum, inter-byte timeout and error reporting.
- Holds the core in reset while programming is active; sits between the UART rx front end, the reset manager and the memory adapters.

Parameters:
- DATA_W, 32, write word width; multiple of 8. BPW = DATA_W/8 bytes per word.
- ADDR_W, 12, word address width per channel.
- NUM_CH, 2, number of target memory channels (>=1).
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYC, 100000, max clk_i cycles between bytes inside a frame.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous active-high reset
- prog_i  in  1  programming mode enable; bytes are ignored while low
- rx_dv_i  in  1  one-cycle strobe, rx_byte_i valid
- rx_byte_i  in  8  received byte
- we_o  out  NUM_CH  one-hot write strobe, one cycle per word
- addr_o  out  ADDR_W  word address of current write
- wdata_o  out  DATA_W  write data
- core_hold_o  out  1  active-high request to hold core/system in reset
- done_o  out  1  one-cycle pulse, frame accepted with checksum OK
- err_o  out  1  one-cycle pulse on any frame error
- err_code_o  out  2  last error: 0 none, 1 checksum, 2 bad channel/length, 3 timeout; sticky until the next SYNC

Behaviour:
- Reset values: we_o=0, addr_o=0, wdata_o=0, core_hold_o=1, done_o=0, err_o=0, err_code_o=0. FSM goes to IDLE; checksum, word count and byte counters are cleared.
- core_hold_o is registered: next = prog_i | (state!=IDLE). It drops 1 cycle after reset when prog_i=0.
- Frame format: SYNC, CHAN, LEN_LO, LEN_HI, LEN*BPW data bytes (little-endian per word), CSUM.
  - CSUM = XOR of all bytes from CHAN through the last data byte.
  - LEN is a word count.
- FSM states and transitions:
  - IDLE: on a byte equal to SYNC_BYTE, go to CHAN and clear csum. Any other byte is ignored.
  - CHAN: latch ch. If ch>=NUM_CH, raise err code 2 and return to IDLE.
  - LEN_LO, then LEN_HI: latch len.
    - len > 2**ADDR_W: err code 2, return to IDLE.
    - len==0: go directly to CSUM.
    - otherwise go to DATA with addr=0.
  - DATA: shift bytes into the word register, LSB byte first. On byte BPW-1:
    - next cycle: we_o[ch]=1, wdata_o=word, addr_o=current addr; then addr increments and the remaining count decrements.
    - after the last word, go to CSUM.
  - CSUM: compare the received byte to csum. Match: done_o pulse, err_code_o=0. Mismatch: err_o pulse, code 1. Either way return to IDLE.
- Words already written are not rolled back on error; software must re-send the frame.
- Timeout: in any state other than IDLE, a counter increments each cycle without rx_dv_i and clears on rx_dv_i. Reaching TIMEOUT_CYC gives err code 3, err_o pulse, return to IDLE.
- prog_i falling mid-frame: abort to IDLE with no error; core_hold_o falls the following cycle.
- rx_dv_i while prog_i=0: ignored.
- Error pulses: err_o pulses on every error, including the silent rejects (codes 2/3 still pulse err_o).
- Address width: addr_o never exceeds 2**ADDR_W-1; the length check guarantees no wrap.
- Throughput: one byte per cycle is sustainable. The write strobe is issued the cycle after the last byte and does not block the next byte.

Decomposition:
- Shared package prog_loader_pkg holds:
  - state enum (IDLE, CHAN, LEN_LO, LEN_HI, DATA, CSUM);
  - err code constants ERR_NONE/ERR_CSUM/ERR_HDR/ERR_TIMEOUT;
  - the default SYNC_BYTE.
- One natural sub-module: prog_word_assembler (byte shift register + byte counter producing word_valid/word). The FSM, timeout, checksum and address logic stay in the top.

Test Plan:
- Reset with prog_i=0 -> all outputs 0 except core_hold_o=1. core_hold_o=0 on the 2nd cycle after reset release.
- prog_i=1, frame A5,00,02,00, 78,56,34,12, EF,BE,AD,DE, csum=0x02^0x78^0x56^0x34^0x12^0xEF^0xBE^0xAD^0xDE -> two strobes:
  - we_o=01, addr 0, wdata 0x12345678;
  - we_o=01, addr 1, wdata 0xDEADBEEF;
  - then done_o pulse and err_code_o=0.
- Same frame with CHAN=01 -> we_o=10. Same frame with CHAN=02 (NUM_CH=2) -> no writes, err_o pulse, err_code_o=2.
- Valid header with a corrupted CSUM byte -> both words written, err_o pulse, err_code_o=1, no done_o.
- TIMEOUT_CYC=50, send A5,00 then idle 50 cycles -> err_o pulse, err_code_o=3, FSM in IDLE. A following valid frame is accepted.
- Drop prog_i after the LEN bytes, or assert rst_i mid-DATA -> no further we_o. Reset returns all outputs to reset values within the same cycle (async).
